// File: rtl/memtest_pkg.sv
// Shared definitions for the memory-tester sequencer: FSM state encoding and PRNG word width.
package memtest_pkg;

    localparam int unsigned MEMTEST_DATA_W = 20;

    typedef enum logic [2:0] {
        IDLE,
        SEED,
        PRIME,
        ISSUE,
        DONE
    } state_e;

endpackage

// File: rtl/memtest_seq_if.sv
// CSR, PRNG and memory-bus signals of the sequencer; master = sequencer side, slave = environment side.
interface memtest_seq_if #(
    parameter int unsigned ADDR_WIDTH = 20,
    parameter int unsigned ERR_WIDTH  = 32
) ();
    import memtest_pkg::*;

    logic                      start;
    logic                      write_pass;
    logic [ADDR_WIDTH-1:0]     base;
    logic [ADDR_WIDTH-1:0]     count;
    logic                      err_clr;
    logic                      busy;
    logic                      done;
    logic                      prng_rst;
    logic                      prng_ce;
    logic [MEMTEST_DATA_W-1:0] prng_rand;
    logic                      mem_stb;
    logic                      mem_we;
    logic [ADDR_WIDTH-1:0]     mem_adr;
    logic [MEMTEST_DATA_W-1:0] mem_dat_w;
    logic                      mem_ack;
    logic [MEMTEST_DATA_W-1:0] mem_dat_r;
    logic [ERR_WIDTH-1:0]      errors;
    logic [ADDR_WIDTH-1:0]     first_err_adr;
    logic                      first_err_valid;

    modport master (
        input  start, write_pass, base, count, err_clr, prng_rand, mem_ack, mem_dat_r,
        output busy, done, prng_rst, prng_ce, mem_stb, mem_we, mem_adr, mem_dat_w,
               errors, first_err_adr, first_err_valid
    );

    modport slave (
        output start, write_pass, base, count, err_clr, prng_rand, mem_ack, mem_dat_r,
        input  busy, done, prng_rst, prng_ce, mem_stb, mem_we, mem_adr, mem_dat_w,
               errors, first_err_adr, first_err_valid
    );

endinterface

// File: rtl/memtest_errcnt.sv
// Saturating mismatch counter with clear priority; MEMTEST_FIRST_ERR_EN adds first-error address capture.
module memtest_errcnt #(
    parameter int unsigned ADDR_WIDTH = 20,
    parameter int unsigned ERR_WIDTH  = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clr_i,
    input  logic                  inc_i,
    input  logic [ADDR_WIDTH-1:0] adr_i,
    output logic [ERR_WIDTH-1:0]  errors_o,
    output logic [ADDR_WIDTH-1:0] first_err_adr_o,
    output logic                  first_err_valid_o
);

    logic [ERR_WIDTH-1:0] errors_q, errors_d;

    always_comb begin
        errors_d = errors_q;
        if (clr_i) begin
            errors_d = '0;
        end else if (inc_i && (errors_q != '1)) begin
            errors_d = errors_q + ERR_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            errors_q <= '0;
        end else begin
            errors_q <= errors_d;
        end
    end

    assign errors_o = errors_q;

`ifdef MEMTEST_FIRST_ERR_EN
    logic [ADDR_WIDTH-1:0] fadr_q, fadr_d;
    logic                  fval_q, fval_d;

    always_comb begin
        fadr_d = fadr_q;
        fval_d = fval_q;
        if (clr_i) begin
            fadr_d = '0;
            fval_d = 1'b0;
        end else if (inc_i && !fval_q) begin
            fadr_d = adr_i;
            fval_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fadr_q <= '0;
            fval_q <= 1'b0;
        end else begin
            fadr_q <= fadr_d;
            fval_q <= fval_d;
        end
    end

    assign first_err_adr_o   = fadr_q;
    assign first_err_valid_o = fval_q;
`else
    logic unused_adr;
    assign unused_adr        = ^adr_i;
    assign first_err_adr_o   = '0;
    assign first_err_valid_o = 1'b0;
`endif

endmodule

// File: rtl/memtest_seq.sv
// Memory-tester sequencer: seeds/steps the external PRNG and issues one strobed access per word.
// First-error capture is built only when MEMTEST_FIRST_ERR_EN is defined.
module memtest_seq
    import memtest_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 20,
    parameter int unsigned ERR_WIDTH  = 32
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    memtest_seq_if.master bus
);

    state_e                state_q;
    logic                  busy_q, done_q, prng_rst_q, prng_ce_q, stb_q, we_q;
    logic [ADDR_WIDTH-1:0] adr_q, rem_q;
    logic                  ack_v, mismatch;

    assign ack_v    = (state_q == ISSUE) && bus.mem_ack;
    assign mismatch = ack_v && !we_q && (bus.mem_dat_r != bus.prng_rand);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            prng_rst_q <= 1'b0;
            prng_ce_q  <= 1'b0;
            stb_q      <= 1'b0;
            we_q       <= 1'b0;
            adr_q      <= '0;
            rem_q      <= '0;
        end else begin
            done_q     <= 1'b0;
            prng_rst_q <= 1'b0;
            prng_ce_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        we_q  <= bus.write_pass;
                        adr_q <= bus.base;
                        rem_q <= bus.count;
                        if (bus.count == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q    <= SEED;
                            busy_q     <= 1'b1;
                            prng_rst_q <= 1'b1;
                        end
                    end
                end
                SEED: begin
                    state_q   <= PRIME;
                    prng_ce_q <= 1'b1;
                end
                PRIME: begin
                    state_q <= ISSUE;
                    stb_q   <= 1'b1;
                end
                ISSUE: begin
                    if (bus.mem_ack) begin
                        adr_q <= adr_q + ADDR_WIDTH'(1);
                        rem_q <= rem_q - ADDR_WIDTH'(1);
                        if (rem_q == ADDR_WIDTH'(1)) begin
                            state_q <= DONE;
                            stb_q   <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // The per-ack advance must reach the PRNG in the ack cycle itself, so it bypasses the register.
    assign bus.prng_ce   = prng_ce_q | ack_v;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.prng_rst  = prng_rst_q;
    assign bus.mem_stb   = stb_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_adr   = adr_q;
    assign bus.mem_dat_w = bus.prng_rand;

    memtest_errcnt #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .ERR_WIDTH  (ERR_WIDTH)
    ) u_errcnt (
        .clk_i             (sys_clk),
        .rst_i             (sys_rst),
        .clr_i             (bus.err_clr),
        .inc_i             (mismatch),
        .adr_i             (adr_q),
        .errors_o          (bus.errors),
        .first_err_adr_o   (bus.first_err_adr),
        .first_err_valid_o (bus.first_err_valid)
    );

endmodule

// File: tb/tb_memtest_seq.sv
// Directed bench for memtest_seq with a PRNG model, a memory responder and a scoreboard of expected accesses.
module tb_memtest_seq;
    import memtest_pkg::*;

    localparam int unsigned AW = 20;
    localparam int unsigned EW = 4;
`ifdef MEMTEST_FIRST_ERR_EN
    localparam bit FE = 1'b1;
`else
    localparam bit FE = 1'b0;
`endif

    typedef struct {
        logic [19:0] adr;
        logic [19:0] dat;
        logic        we;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    memtest_seq_if #(.ADDR_WIDTH(AW), .ERR_WIDTH(EW)) bus ();

    memtest_seq #(.ADDR_WIDTH(AW), .ERR_WIDTH(EW)) dut (
        .sys_clk (clk),
        .sys_rst (rst),
        .bus     (bus)
    );

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];
    logic [19:0] mem [int];

    int ack_max   = 0;
    int ack_fixed = -1;
    int ack_count = 0;
    bit flip_en   = 1'b0;
    bit flip_all  = 1'b0;
    bit clr_on_last = 1'b0;
    logic [19:0] flip_adr = '0;
    logic clr_stim = 1'b0;
    logic clr_resp = 1'b0;
    assign bus.err_clr = clr_stim | clr_resp;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [19:0] prng_next(input logic [19:0] x);
        return x * 20'd13 + 20'h09E37;
    endfunction

    function automatic logic [19:0] prng_word(input int k);
        logic [19:0] x = '0;
        for (int i = 0; i < k; i++) x = prng_next(x);
        return x;
    endfunction

    // External PRNG model
    logic [19:0] prng_q = '0;
    always @(posedge clk) begin
        if (bus.prng_rst)     prng_q <= '0;
        else if (bus.prng_ce) prng_q <= prng_next(prng_q);
    end
    assign bus.prng_rand = prng_q;

    // Memory responder: random/fixed ack latency, checks each access against the scoreboard
    initial begin : responder
        int          wait_cnt;
        logic [19:0] hold_adr;
        logic        hold_we;
        logic [19:0] d;
        exp_t        e;
        wait_cnt = -1;
        hold_adr = '0;
        hold_we  = 1'b0;
        bus.mem_ack   = 1'b0;
        bus.mem_dat_r = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.mem_ack = 1'b0;
            clr_resp    = 1'b0;
            if (rst) begin
                wait_cnt = -1;
            end else if (bus.mem_stb) begin
                if (wait_cnt < 0) begin
                    wait_cnt = (ack_fixed >= 0) ? ack_fixed : int'($urandom_range(ack_max, 0));
                    hold_adr = bus.mem_adr;
                    hold_we  = bus.mem_we;
                end else begin
                    check("adr_stable", 32'(bus.mem_adr), 32'(hold_adr));
                    check("we_stable", 32'(bus.mem_we), 32'(hold_we));
                end
                if (wait_cnt == 0) begin
                    wait_cnt = -1;
                    check("access_expected", 32'(sb.size() != 0), 32'd1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        check("ack_adr", 32'(bus.mem_adr), 32'(e.adr));
                        check("ack_we", 32'(bus.mem_we), 32'(e.we));
                        if (e.we) begin
                            check("ack_dat_w", 32'(bus.mem_dat_w), 32'(e.dat));
                            mem[int'(e.adr)] = bus.mem_dat_w;
                        end else begin
                            d = mem.exists(int'(e.adr)) ? mem[int'(e.adr)] : e.dat;
                            if (flip_all || (flip_en && e.adr == flip_adr)) d = d ^ 20'h00020;
                            bus.mem_dat_r = d;
                        end
                        if (clr_on_last && sb.size() == 0) clr_resp = 1'b1;
                    end
                    bus.mem_ack = 1'b1;
                    ack_count++;
                end else begin
                    wait_cnt--;
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic run_pass(input bit we, input logic [19:0] base, input logic [19:0] cnt,
                            input int exp_lat);
        int lat;
        exp_t e;
        for (int i = 0; i < int'(cnt); i++) begin
            e.adr = base + 20'(i);
            e.dat = prng_word(i + 1);
            e.we  = we;
            sb.push_back(e);
        end
        bus.write_pass = we;
        bus.base       = base;
        bus.count      = cnt;
        bus.start      = 1'b1;
        tick();
        bus.start = 1'b0;
        if (cnt == '0) begin
            check("zc_done", 32'(bus.done), 32'd1);
            check("zc_busy", 32'(bus.busy), 32'd0);
            check("zc_prng_rst", 32'(bus.prng_rst), 32'd0);
            tick();
            check("zc_stb", 32'(bus.mem_stb), 32'd0);
            check("zc_prng_rst2", 32'(bus.prng_rst), 32'd0);
            check("zc_done_drop", 32'(bus.done), 32'd0);
            return;
        end
        check("seed_busy", 32'(bus.busy), 32'd1);
        check("seed_prng_rst", 32'(bus.prng_rst), 32'd1);
        check("seed_stb", 32'(bus.mem_stb), 32'd0);
        tick();
        check("prime_prng_ce", 32'(bus.prng_ce), 32'd1);
        check("prime_prng_rst", 32'(bus.prng_rst), 32'd0);
        tick();
        check("issue_stb", 32'(bus.mem_stb), 32'd1);
        lat = 3;
        while (!bus.done && lat < 400) begin
            tick();
            lat++;
        end
        check("done_seen", 32'(bus.done), 32'd1);
        if (exp_lat >= 0) check("done_latency", 32'(lat), 32'(exp_lat));
        check("busy_at_done", 32'(bus.busy), 32'd0);
        check("sb_drained", 32'(sb.size()), 32'd0);
        tick();
        check("done_pulse", 32'(bus.done), 32'd0);
    endtask

    initial begin : stim
        int k;
        int base_cnt;
        exp_t e;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.write_pass = 1'b0;
        bus.base  = '0;
        bus.count = '0;
        repeat (3) @(posedge clk);
        #3;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_prng_rst", 32'(bus.prng_rst), 32'd0);
        check("rst_prng_ce", 32'(bus.prng_ce), 32'd0);
        check("rst_stb", 32'(bus.mem_stb), 32'd0);
        check("rst_we", 32'(bus.mem_we), 32'd0);
        check("rst_adr", 32'(bus.mem_adr), 32'd0);
        check("rst_errors", 32'(bus.errors), 32'd0);
        check("rst_fev", 32'(bus.first_err_valid), 32'd0);
        check("rst_fea", 32'(bus.first_err_adr), 32'd0);
        rst = 1'b0;
        tick();

        // write then clean verify, zero-wait acks
        run_pass(1'b1, 20'h00010, 20'd4, 7);
        check("wr_errors", 32'(bus.errors), 32'd0);
        run_pass(1'b0, 20'h00010, 20'd4, 7);
        check("vf_errors", 32'(bus.errors), 32'd0);
        check("vf_fev", 32'(bus.first_err_valid), 32'd0);

        // single bad bit at 0x12 with random ack delays
        ack_max = 3; flip_en = 1'b1; flip_adr = 20'h00012;
        run_pass(1'b0, 20'h00010, 20'd4, -1);
        check("bad1_errors", 32'(bus.errors), 32'd1);
        check("bad1_fea", 32'(bus.first_err_adr), FE ? 32'h12 : 32'h0);
        check("bad1_fev", 32'(bus.first_err_valid), 32'(FE));
        flip_adr = 20'h00011;
        run_pass(1'b0, 20'h00010, 20'd4, -1);
        check("bad2_errors", 32'(bus.errors), 32'd2);
        check("bad2_fea_kept", 32'(bus.first_err_adr), FE ? 32'h12 : 32'h0);
        flip_en = 1'b0; ack_max = 0;

        run_pass(1'b1, 20'h00040, 20'd0, -1);
        check("zc_errors", 32'(bus.errors), 32'd2);

        // address wrap
        run_pass(1'b1, 20'hFFFFE, 20'd3, 6);
        flip_all = 1'b1;
        run_pass(1'b0, 20'hFFFFE, 20'd3, 6);
        flip_all = 1'b0;
        check("wrap_errors", 32'(bus.errors), 32'd5);
        check("wrap_fea", 32'(bus.first_err_adr), FE ? 32'h12 : 32'h0);

        clr_stim = 1'b1;
        tick();
        clr_stim = 1'b0;
        check("clr_errors", 32'(bus.errors), 32'd0);
        check("clr_fev", 32'(bus.first_err_valid), 32'd0);
        check("clr_fea", 32'(bus.first_err_adr), 32'd0);

        // saturation at all-ones
        run_pass(1'b1, 20'h00000, 20'd20, 23);
        flip_all = 1'b1;
        run_pass(1'b0, 20'h00000, 20'd20, 23);
        check("sat_errors", 32'(bus.errors), 32'hF);
        check("sat_fev", 32'(bus.first_err_valid), 32'(FE));
        run_pass(1'b0, 20'h00005, 20'd1, 4);
        check("sat_hold", 32'(bus.errors), 32'hF);

        // err_clr coincident with the final mismatch ack
        clr_on_last = 1'b1;
        run_pass(1'b0, 20'h00010, 20'd4, 7);
        clr_on_last = 1'b0; flip_all = 1'b0;
        check("clrprio_errors", 32'(bus.errors), 32'd0);
        check("clrprio_fev", 32'(bus.first_err_valid), 32'd0);

        // reset during the second word's wait
        ack_fixed = 3;
        for (int i = 0; i < 4; i++) begin
            e.adr = 20'h00100 + 20'(i);
            e.dat = prng_word(i + 1);
            e.we  = 1'b1;
            sb.push_back(e);
        end
        bus.write_pass = 1'b1; bus.base = 20'h00100; bus.count = 20'd4; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        base_cnt = ack_count;
        k = 0;
        while (ack_count == base_cnt && k < 50) begin
            tick();
            k++;
        end
        check("mid_first_ack", 32'(ack_count - base_cnt), 32'd1);
        tick();
        check("mid_stb_before", 32'(bus.mem_stb), 32'd1);
        check("mid_adr_before", 32'(bus.mem_adr), 32'h101);
        #1 rst = 1'b1;
        #1;
        check("mid_stb", 32'(bus.mem_stb), 32'd0);
        check("mid_busy", 32'(bus.busy), 32'd0);
        check("mid_we", 32'(bus.mem_we), 32'd0);
        check("mid_adr", 32'(bus.mem_adr), 32'd0);
        check("mid_prng_ce", 32'(bus.prng_ce), 32'd0);
        check("mid_errors", 32'(bus.errors), 32'd0);
        tick();
        rst = 1'b0;
        sb.delete();
        ack_fixed = -1; ack_max = 0;
        tick();
        check("mid_no_done", 32'(bus.done), 32'd0);
        tick();
        check("mid_no_done2", 32'(bus.done), 32'd0);
        run_pass(1'b1, 20'h00100, 20'd4, 7);
        check("fresh_errors", 32'(bus.errors), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/memtest_seq.md
# memtest_seq

Sequencer for the memory tester: seeds and steps the external 20-bit pseudo-random generator, and issues one write or read access per generated word over a strobe/acknowledge bus. On read passes it compares returned data against the regenerated sequence and keeps a saturating error count. It sits between the tester's CSR bank and the memory-bus master adapter, and drives the PRNG's reset and clock-enable.

## Interface
- ADDR_WIDTH, 20: word-address width; also the width of `count`.
- ERR_WIDTH, 32: error counter width.

- sys_clk  in  1  clock; all logic on rising edge.
- sys_rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle pulse; begins a pass; ignored while `busy`.
- write_pass  in  1  sampled with `start`; 1 = write pass, 0 = verify pass.
- base  in  ADDR_WIDTH  first word address, sampled with `start`.
- count  in  ADDR_WIDTH  number of words, sampled with `start`.
- err_clr  in  1  clears `errors` (and first-error capture).
- busy  out  1  high from the cycle after an accepted `start` until `done`.
- done  out  1  one-cycle pulse at pass end.
- prng_rst  out  1  synchronous reset to PRNG (state and output to 0).
- prng_ce  out  1  PRNG advance; PRNG output updates the edge after `prng_ce`.
- prng_rand  in  20  PRNG output.
- mem_stb  out  1  access request.
- mem_we  out  1  access direction.
- mem_adr  out  ADDR_WIDTH  word address.
- mem_dat_w  out  20  write data; equals `prng_rand`.
- mem_ack  in  1  access complete; `mem_dat_r` valid in the same cycle.
- mem_dat_r  in  20  read data.
- errors  out  ERR_WIDTH  mismatch count, saturating.
- first_err_adr  out  ADDR_WIDTH  address of first mismatch (see Configuration).
- first_err_valid  out  1  `first_err_adr` holds a capture.

## Operation
- States: IDLE, SEED, PRIME, ISSUE, DONE.
- IDLE: on `start`, latch `write_pass`, `base`, `count`.
  - If `count` is 0: go to DONE. No PRNG or bus activity.
  - Otherwise: go to SEED.
- SEED: `prng_rst`=1 for one cycle; go to PRIME.
- PRIME: `prng_ce`=1 for one cycle; go to ISSUE. The first word is valid on `prng_rand` on entry to ISSUE.
- ISSUE: `mem_stb`=1, `mem_we`=latched `write_pass`, `mem_adr`=current address.
  - All three are held stable until `mem_ack`.
  - On an ack cycle:
    - `prng_ce`=1.
    - Address increments, wrapping modulo 2^ADDR_WIDTH.
    - Remaining count decrements.
    - In a verify pass, if `mem_dat_r` != `prng_rand`, `errors` increments.
  - After the ack: if the remaining count was 1, go to DONE; otherwise stay in ISSUE. `mem_stb` stays high, so back-to-back accesses are allowed.
- DONE: `done`=1 for one cycle; go to IDLE.
- `errors`:
  - Saturates at all-ones.
  - Write passes never change it.
  - It is not cleared by `start`.
  - When `err_clr` and an increment occur in the same cycle, `err_clr` wins and the result is 0.
- `mem_ack` outside ISSUE is ignored.

## Timing
- Reset values: state IDLE; `busy`, `done`, `prng_rst`, `prng_ce`, `mem_stb`, `mem_we`, `errors`, `first_err_valid` = 0; `mem_adr`, `first_err_adr` = 0.
- Reset asserted mid-pass: the pass is abandoned immediately. `mem_stb` drops asynchronously and no `done` is issued.
- `start` at edge N:
  - `busy` rises at N+1 (SEED).
  - PRIME at N+2.
  - `mem_stb` rises at N+3.
- With zero-wait ack, one word completes per cycle. A pass of C words ends with `done` C+3 cycles after the `start` edge, and `busy` falls with `done`.
- `count`=0: `done` is asserted at N+1, and `busy` is never asserted.
- `errors` updates on the edge that ends the ack cycle.

## Configuration
- Macro `MEMTEST_FIRST_ERR_EN`.
- Defined: on the first verify mismatch while `first_err_valid`=0, capture `mem_adr` into `first_err_adr` and set `first_err_valid`. Both are cleared by `err_clr` or reset.
- Undefined: no capture registers; `first_err_adr`=0 and `first_err_valid`=0 constantly; ports retained.

## Structure
- Shared package `memtest_pkg`:
  - State enum (IDLE, SEED, PRIME, ISSUE, DONE).
  - Constant `MEMTEST_DATA_W`=20.
- Sub-module `memtest_errcnt`:
  - Saturating counter with clear-priority.
  - Optional first-error capture under `MEMTEST_FIRST_ERR_EN`.
- The FSM and address/count registers stay in `memtest_seq`. The PRNG is instantiated by the parent, not here.

## Test plan
- Write pass, base=0x00010, count=4, ack every cycle: 4 strobed writes at 0x00010..0x00013 with `mem_dat_w` equal to PRNG words 1..4 from seed 0; `done` at start+7; `errors` stays 0.
- Verify pass, same parameters, memory model returns the written data: `errors`=0 and `first_err_valid`=0.
- Verify pass, data bit 5 flipped at address 0x00012, random ack delays of 0–3 cycles: `errors`=1, `first_err_adr`=0x00012 (macro defined), and `mem_adr`/`mem_we` stable while awaiting ack.
- count=0: `done` one cycle after `start`; no `mem_stb`, no `prng_rst`.
- base=0xFFFFE, count=3: addresses 0xFFFFE, 0xFFFFF, 0x00000. `errors` preset to all-ones with a mismatch injected stays all-ones; `err_clr` pulsed in the same cycle as a mismatch ack gives `errors`=0.
- `sys_rst` asserted during the 2nd word's wait: `mem_stb`=0 immediately and all outputs at reset values. A subsequent `start` (during the pass, or after it) runs a fresh pass from SEED.
